mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the E stage of the pipelined CPU.
- Accepts mult/multu/div/divu/mthi/mtlo operations and owns the HI/LO architectural registers.
- Models fixed multi-cycle latency with a busy counter.
- Generates the D-stage stall request for any instruction that touches the MDU while it is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is a valid MDU operation this cycle
- md_op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7 reserved
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
- rt_val  input  32  forwarded rt operand (divisor / multiplier)
- md_use_d  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- hi  output  32  committed HI register
- lo  output  32  committed LO register
- busy  output  1  operation in flight
- stall_md  output  1  stall request to the hazard unit

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: hi=0, lo=0, busy=0, state=IDLE, counter=0, shadow registers=0. Reset mid-operation aborts the operation; no commit occurs.
- States: IDLE, MUL_BUSY, DIV_BUSY. busy = (state != IDLE), registered.
- From IDLE with start=1, sampled at edge N:
  - mult/multu: compute the 64-bit product into shadow {sh_hi, sh_lo}. mult is signed x signed; multu is unsigned. Load counter=MULT_CYCLES and go to MUL_BUSY.
  - div/divu: sh_lo=quotient, sh_hi=remainder. Signed division truncates toward zero, and the remainder takes the sign of the dividend. Load counter=DIV_CYCLES and go to DIV_BUSY.
  - div overflow (0x80000000 / 0xFFFFFFFF): sh_lo=0x80000000, sh_hi=0.
  - div/divu with rt_val=0: state still goes to DIV_BUSY for DIV_CYCLES, but no commit at the end; hi/lo stay unchanged.
  - mthi/mtlo: write rs_val into hi/lo at edge N; stay in IDLE; busy stays 0.
  - md_op 6/7: ignored; no state change.
- In a BUSY state: counter decrements each edge. At the edge where counter==1, commit {hi, lo} <= {sh_hi, sh_lo} and go to IDLE.
- Resulting timing: busy=1 during cycles N+1 .. N+CYCLES. New hi/lo are visible and busy=0 in cycle N+CYCLES+1.
- hi/lo hold their old values for the whole busy window. mfhi/mflo cannot observe partial results.
- start=1 while busy: ignored; no restart, no operand capture. The hazard unit guarantees this does not occur, and the bench checks the ignore behaviour.
- stall_md = md_use_d & (busy | start), combinational. This covers the cycle the op is issued (start=1, busy still 0).
- mthi/mtlo while busy: ignored. These are covered by stall_md.
- All arithmetic is done in 64-bit (multiply) or 32-bit (divide) with explicit signed casts. No X propagation on div-by-zero: the quotient/remainder logic must gate the divisor.

Test Plan:
- Reset then idle:
  - hi=0, lo=0, busy=0, stall_md=0 with md_use_d=1.
  - Assert reset during the 3rd busy cycle of a div: next cycle busy=0, hi/lo=0.
- mult rs=0xFFFFFFFD (-3), rt=5, start at edge N:
  - busy=1 for exactly 5 cycles; hi/lo unchanged throughout.
  - In cycle N+6: hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - multu with the same operands gives hi=0x00000004, lo=0xFFFFFFF1.
- divu 100/7: busy for 10 cycles, then lo=14, hi=2.
- div -7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- Div by zero: preload hi=0x11111111, lo=0x22222222 via mthi/mtlo (each visible next cycle, busy stays 0). Then div rs=9, rt=0: busy for 10 cycles, hi/lo remain 0x11111111/0x22222222.
- Stall and ignore:
  - md_use_d=1 together with start=1 -> stall_md=1 in the issue cycle.
  - stall_md=1 for all busy cycles, and 0 in the first cycle after the commit.
  - During busy, issue start with mult 2*2 -> ignored; the final hi/lo match the original operation only.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: owns HI/LO, models fixed MDU latency
// with a busy counter, and raises the D-stage stall while the unit is occupied.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] DIV_BUSY = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]  stateReg;
    logic [3:0]  cntReg;
    logic [31:0] hiReg, loReg;
    logic [31:0] shHiReg, shLoReg;
    logic        commitReg;

    logic [63:0] prodSigned, prodUnsigned;
    logic [31:0] divisorSafe;
    logic [31:0] absDividend, absDivisor;
    logic [31:0] magQuot, magRem;
    logic [31:0] sQuot, sRem, uQuot, uRem;

    assign prodSigned   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prodUnsigned = {32'd0, rs_val} * {32'd0, rt_val};

    // Divisor is forced to 1 when zero so the dividers never see x/0; the result is discarded.
    assign divisorSafe = (rt_val == 32'd0) ? 32'd1 : rt_val;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend.
    // 0x80000000 / -1 falls out as magnitude 0x80000000 negated back to 0x80000000.
    assign absDividend = rs_val[31]      ? (32'd0 - rs_val)      : rs_val;
    assign absDivisor  = divisorSafe[31] ? (32'd0 - divisorSafe) : divisorSafe;
    assign magQuot     = absDividend / absDivisor;
    assign magRem      = absDividend % absDivisor;
    assign sQuot       = (rs_val[31] ^ divisorSafe[31]) ? (32'd0 - magQuot) : magQuot;
    assign sRem        = rs_val[31] ? (32'd0 - magRem) : magRem;
    assign uQuot       = rs_val / divisorSafe;
    assign uRem        = rs_val % divisorSafe;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg  <= IDLE;
            cntReg    <= 4'd0;
            hiReg     <= 32'd0;
            loReg     <= 32'd0;
            shHiReg   <= 32'd0;
            shLoReg   <= 32'd0;
            commitReg <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                {shHiReg, shLoReg} <= (md_op == OP_MULT) ? prodSigned : prodUnsigned;
                                cntReg    <= 4'(MULT_CYCLES);
                                stateReg  <= MUL_BUSY;
                                commitReg <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                shLoReg   <= (md_op == OP_DIV) ? sQuot : uQuot;
                                shHiReg   <= (md_op == OP_DIV) ? sRem  : uRem;
                                cntReg    <= 4'(DIV_CYCLES);
                                stateReg  <= DIV_BUSY;
                                commitReg <= (rt_val != 32'd0);
                            end
                            OP_MTHI: hiReg <= rs_val;
                            OP_MTLO: loReg <= rs_val;
                            default: ;
                        endcase
                    end
                end
                MUL_BUSY, DIV_BUSY: begin
                    // Issue while busy is dropped on purpose: no restart, no operand capture.
                    if (cntReg == 4'd1) begin
                        if (commitReg) begin
                            hiReg <= shHiReg;
                            loReg <= shLoReg;
                        end
                        stateReg <= IDLE;
                        cntReg   <= 4'd0;
                    end else begin
                        cntReg <= cntReg - 4'd1;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                    cntReg   <= 4'd0;
                end
            endcase
        end
    end

    assign hi       = hiReg;
    assign lo       = loReg;
    assign busy     = (stateReg != IDLE);
    assign stall_md = md_use_d & (busy | start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected HI/LO and busy length,
// a monitor checks hold values during busy and the committed result when busy drops.
module tb_mdu_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        md_use_d = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, stall_md;

    mdu_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .md_use_d(md_use_d),
        .hi(hi), .lo(lo), .busy(busy), .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] preHi;
        logic [31:0] preLo;
        logic [31:0] postHi;
        logic [31:0] postLo;
        int          len;
    } txn_t;

    txn_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Architectural reference: what HI/LO become after the op and how long the unit is busy.
    function automatic void refOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hiIn, input logic [31:0] loIn,
                                  output logic [31:0] hiOut, output logic [31:0] loOut,
                                  output int len);
        longint      x, y, q, r;
        logic [63:0] p;
        hiOut = hiIn;
        loOut = loIn;
        len   = 0;
        case (op)
            3'd0: begin
                x = $signed(a); y = $signed(b); q = x * y;
                {hiOut, loOut} = q;
                len = MULT_CYCLES;
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                {hiOut, loOut} = p;
                len = MULT_CYCLES;
            end
            3'd2: begin
                len = DIV_CYCLES;
                if (b != 32'd0) begin
                    x = $signed(a); y = $signed(b);
                    q = x / y; r = x % y;
                    loOut = q[31:0]; hiOut = r[31:0];
                end
            end
            3'd3: begin
                len = DIV_CYCLES;
                if (b != 32'd0) begin
                    loOut = a / b; hiOut = a % b;
                end
            end
            3'd4: hiOut = a;
            3'd5: loOut = a;
            default: ;
        endcase
    endfunction

    // Monitor: samples just after each rising edge.
    initial begin
        bit   prevBusy = 1'b0;
        bit   valid = 1'b0;
        int   len = 0;
        txn_t cur;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (prevBusy && sb.size() > 0) void'(sb.pop_front());
                prevBusy = 1'b0;
                len = 0;
            end else begin
                if (busy) begin
                    if (!prevBusy) begin
                        len = 0;
                        valid = (sb.size() > 0);
                        if (valid) cur = sb[0];
                        else chk("busy_without_txn", 64'd1, 64'd0);
                    end
                    len++;
                    if (valid) begin
                        chk("hold_hi", hi, cur.preHi);
                        chk("hold_lo", lo, cur.preLo);
                    end
                end else if (prevBusy && valid) begin
                    cur = sb.pop_front();
                    chk("commit_hi", hi, cur.postHi);
                    chk("commit_lo", lo, cur.postLo);
                    chk("busy_len", 64'(len), 64'(cur.len));
                    $display("TXN hi=%08h lo=%08h busy_cycles=%0d", hi, lo, len);
                    valid = 1'b0;
                end
                prevBusy = busy;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit useD, input bit inject, input logic [2:0] injOp,
                         input logic [31:0] injA, input logic [31:0] injB);
        logic [31:0] nh, nl;
        int          len;
        txn_t        t;
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b; md_use_d = useD;
        #1 chk("stall_issue", stall_md, useD);
        refOp(op, a, b, mHi, mLo, nh, nl, len);
        if (len > 0) begin
            t = '{mHi, mLo, nh, nl, len};
            sb.push_back(t);
        end
        mHi = nh;
        mLo = nl;
        @(negedge clk);
        start = 1'b0; md_op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
        if (len == 0) begin
            #1;
            chk("idle_busy", busy, 1'b0);
            chk("imm_hi", hi, mHi);
            chk("imm_lo", lo, mLo);
            $display("TXN op=%0d hi=%08h lo=%08h", op, hi, lo);
        end else begin
            for (int k = 1; k <= len; k++) begin
                if (k > 1) @(negedge clk);
                if (inject && k == 2) begin
                    start = 1'b1; md_op = injOp; rs_val = injA; rt_val = injB;
                end else begin
                    start = 1'b0;
                end
                #1;
                chk("stall_busy", stall_md, useD);
                chk("busy_on", busy, 1'b1);
            end
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("stall_after", stall_md, 1'b0);
            chk("busy_off", busy, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b;
        logic [2:0]  op;
        txn_t        t;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        md_use_d = 1'b1;
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stall_md, 1'b0);

        issue(3'd0, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);
        issue(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("multu_hi", hi, 32'h00000004);
        chk("multu_lo", lo, 32'hFFFFFFF1);
        issue(3'd3, 32'd100, 32'd7, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_lo", lo, 32'hFFFFFFFD);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("divovf_hi", hi, 32'd0);
        chk("divovf_lo", lo, 32'h80000000);
        issue(3'd4, 32'h11111111, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd5, 32'h22222222, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd2, 32'd9, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("div0_hi", hi, 32'h11111111);
        chk("div0_lo", lo, 32'h22222222);
        // Ignored mult 2*2 issued in the middle of a divide.
        issue(3'd3, 32'd100, 32'd7, 1'b1, 1'b1, 3'd0, 32'd2, 32'd2);
        chk("ign_hi", hi, 32'd2);
        chk("ign_lo", lo, 32'd14);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                default: b = $urandom;
            endcase
            issue(op, a, b, 1'($urandom), ($urandom_range(0, 2) == 0),
                  3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        // Reset in the 3rd busy cycle of a divide aborts it and clears HI/LO.
        issue(3'd4, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; rs_val = 32'd50; rt_val = 32'd3; md_use_d = 1'b1;
        t = '{mHi, mLo, 32'd2, 32'd16, DIV_CYCLES};
        sb.push_back(t);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mHi = 32'd0;
        mLo = 32'd0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_stall", stall_md, 1'b0);
        $display("TXN reset-abort hi=%08h lo=%08h busy=%0b", hi, lo, busy);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
